// File: rtl/keypad_pkg.sv
//==============================================================================
// keypad_pkg -- shared types and width helpers for the keypad scanner
// Rev 1.0
//==============================================================================
`default_nettype none

package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } kp_state_t;

  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_ONE   = 2'd1,
    RES_MULTI = 2'd2
  } scan_result_t;

  function automatic int code_width(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_event_fifo.sv
//==============================================================================
// keypad_event_fifo -- small key-event FIFO with sticky overflow flag
// Rev 1.0
//==============================================================================
`default_nettype none

module keypad_event_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot being written, so a full FIFO still accepts
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !do_push) overflow <= 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
//==============================================================================
// keypad_scan_ctrl -- ROWS x COLS keypad scanner with debounce, ghost rejection
// and event FIFO. Optional auto-repeat: define KEYPAD_AUTOREPEAT_EN.  Rev 1.0
//==============================================================================
`default_nettype none

module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter  int ROWS           = 4,
  parameter  int COLS           = 4,
  parameter  int SCAN_DIV       = 50000,
  parameter  int DEBOUNCE_SCANS = 3,
  parameter  int FIFO_DEPTH     = 4,
  parameter  int REPEAT_DELAY   = 50,
  parameter  int REPEAT_RATE    = 10,
  localparam int CODE_W         = code_width(ROWS, COLS),
  localparam int CNT_W          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROWS-1:0]   row_in,
  output logic [COLS-1:0]   col_out,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              key_held,
  output logic              overflow,
  output logic [CNT_W-1:0]  fifo_count
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);

  // Out-of-range configurations elaborate this empty marker block
  if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 || SCAN_DIV < 2 ||
      DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
  end

  logic [DIV_W-1:0] div_cnt;
  logic [COL_W-1:0] col_idx;
  logic [ROWS-1:0]  row_q;
  logic             tick;
  logic             scan_done;

  assign tick      = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign scan_done = tick && (col_idx == COL_W'(COLS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      col_idx <= '0;
      row_q   <= '0;
    end else begin
      row_q <= row_in;
      if (tick) begin
        div_cnt <= '0;
        col_idx <= scan_done ? '0 : col_idx + COL_W'(1);
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  assign col_out = COLS'(1) << col_idx;

  // Per-column row count (saturating at 2) and index of the closed row
  logic [1:0]       row_n;
  logic [ROW_W-1:0] row_idx;

  always_comb begin
    row_n   = 2'd0;
    row_idx = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (row_q[r]) begin
        row_idx = ROW_W'(r);
        if (row_n != 2'd2) row_n = row_n + 2'd1;
      end
    end
  end

  logic [1:0]        acc_n;
  logic [1:0]        acc_sum;
  logic [2:0]        sum_full;
  logic [CODE_W-1:0] acc_code;
  logic [CODE_W-1:0] acc_code_nxt;
  logic [CODE_W-1:0] row_code;
  scan_result_t      res;

  assign row_code     = CODE_W'(row_idx) * CODE_W'(COLS) + CODE_W'(col_idx);
  assign sum_full     = {1'b0, acc_n} + {1'b0, row_n};
  assign acc_sum      = (sum_full >= 3'd2) ? 2'd2 : sum_full[1:0];
  assign acc_code_nxt = (acc_n == 2'd0) ? row_code : acc_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_n    <= 2'd0;
      acc_code <= '0;
    end else if (scan_done) begin
      acc_n    <= 2'd0;
      acc_code <= '0;
    end else if (tick) begin
      acc_n    <= acc_sum;
      acc_code <= acc_code_nxt;
    end
  end

  always_comb begin
    case (acc_sum)
      2'd0:    res = RES_NONE;
      2'd1:    res = RES_ONE;
      default: res = RES_MULTI;
    endcase
  end

  kp_state_t         state;
  kp_state_t         state_nxt;
  logic [DEB_W-1:0]  cnt;
  logic [DEB_W-1:0]  cnt_nxt;
  logic [DEB_W-1:0]  cnt_inc;
  logic [CODE_W-1:0] cand;
  logic [CODE_W-1:0] cand_nxt;
  logic              push;
  logic              push_nxt;

  assign cnt_inc = cnt + DEB_W'(1);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  logic [REP_W-1:0] rep;
  logic [REP_W-1:0] rep_nxt;
  logic [REP_W-1:0] rep_inc;

  assign rep_inc = rep + REP_W'(1);

  always_ff @(posedge clk) begin
    if (rst) rep <= '0;
    else     rep <= rep_nxt;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SCAN;
      cnt   <= '0;
      cand  <= '0;
      push  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cand  <= cand_nxt;
      push  <= push_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    push_nxt  = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_nxt   = rep;
`endif
    if (scan_done) begin
      case (state)
        SCAN: begin
          if (res == RES_ONE) begin
            cand_nxt = acc_code_nxt;
            if (DEBOUNCE_SCANS == 1) begin
              state_nxt = HELD;
              push_nxt  = 1'b1;
              cnt_nxt   = '0;
            end else begin
              state_nxt = CONFIRM;
              cnt_nxt   = DEB_W'(1);
            end
          end
        end
        CONFIRM: begin
          if (res == RES_ONE && acc_code_nxt == cand) begin
            if (cnt_inc == DEB_W'(DEBOUNCE_SCANS)) begin
              state_nxt = HELD;
              push_nxt  = 1'b1;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            state_nxt = SCAN;
            cnt_nxt   = '0;
          end
        end
        HELD: begin
          // Any closure, even a different key or a ghost pattern, keeps the key held
          if (res == RES_NONE) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_nxt = SCAN;
              cnt_nxt   = '0;
            end else begin
              state_nxt = RELEASE;
              cnt_nxt   = DEB_W'(1);
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_nxt = '0;
          end else begin
            rep_nxt = rep_inc;
            if (rep_inc == REP_W'(REPEAT_DELAY)) begin
              push_nxt = 1'b1;
            end else if (rep_inc == REP_W'(REPEAT_DELAY + REPEAT_RATE)) begin
              push_nxt = 1'b1;
              rep_nxt  = REP_W'(REPEAT_DELAY);
            end
`endif
          end
        end
        RELEASE: begin
          if (res == RES_NONE) begin
            if (cnt_inc == DEB_W'(DEBOUNCE_SCANS)) begin
              state_nxt = SCAN;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            state_nxt = HELD;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = SCAN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign key_held = (state == HELD) || (state == RELEASE);

  logic fifo_empty;

  keypad_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (cand),
    .pop       (key_valid && key_ready),
    .pop_data  (key_code),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .overflow  (overflow)
  );

  assign key_valid = !fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
//==============================================================================
// tb_keypad_scan_ctrl -- directed self-checking bench for keypad_scan_ctrl
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_keypad_scan_ctrl;

  localparam int SCAN_CYC = 16;  // 4 columns x SCAN_DIV 4

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_ready = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        overflow;
  logic [2:0]  fifo_count;
  logic [15:0] pressed = '0;

  int n_checks = 0;
  int n_pass   = 0;
  int ev_q[$];

  always #5 clk = ~clk;

  keypad_scan_ctrl #(
    .ROWS           (4),
    .COLS           (4),
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3),
    .FIFO_DEPTH     (4),
    .REPEAT_DELAY   (5),
    .REPEAT_RATE    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row_in     (row_in),
    .col_out    (col_out),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_held   (key_held),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  // Keypad matrix: bit r*4+c closes row r onto column c
  always_comb begin
    row_in = '0;
    for (int r = 0; r < 4; r++) row_in[r] = |(pressed[r*4 +: 4] & col_out);
  end

  always @(negedge clk) begin
    if (!rst && key_valid && key_ready) ev_q.push_back(int'(key_code));
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    pressed = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    ev_q.delete();
  endtask

  task automatic scans(input int n);
    repeat (SCAN_CYC * n) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    key_ready = 1'b1;
    @(posedge clk);
    #1 key_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state and column ring
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_col_out", int'(col_out), 1);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_code", int'(key_code), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_fifo_count", int'(fifo_count), 0);
    check("rst_key_held", int'(key_held), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("col_hold_3clk", int'(col_out), 1);
    @(posedge clk);
    @(negedge clk);
    check("col_rot_4clk", int'(col_out), 2);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("col_wrap_16clk", int'(col_out), 1);

    // Clean press and release of key 6
    do_reset();
    key_ready = 1'b1;
    pressed   = 16'(1) << 6;
    scans(2);
    check("press_held_2scans", int'(key_held), 0);
    scans(1);
    check("press_held_3scans", int'(key_held), 1);
    pressed = '0;
    scans(2);
    check("release_held_2scans", int'(key_held), 1);
    check("press_event_count", ev_q.size(), 1);
    if (ev_q.size() > 0) check("press_event_code", ev_q[0], 6);
    scans(1);
    check("release_held_3scans", int'(key_held), 0);
    scans(2);
    check("release_no_event", ev_q.size(), 1);
    check("release_key_valid", int'(key_valid), 0);

    // Bounce: 2 scans on, 1 off, 3 on
    do_reset();
    key_ready = 1'b1;
    pressed   = 16'(1) << 6;
    scans(2);
    pressed = '0;
    scans(1);
    pressed = 16'(1) << 6;
    scans(2);
    check("bounce_not_yet_held", int'(key_held), 0);
    check("bounce_no_early_event", ev_q.size(), 0);
    scans(1);
    repeat (3) @(posedge clk);
    #1;
    check("bounce_held", int'(key_held), 1);
    check("bounce_event_count", ev_q.size(), 1);
    if (ev_q.size() > 0) check("bounce_event_code", ev_q[0], 6);

    // Ghost: rows 0 and 1 closed on column 0
    do_reset();
    key_ready = 1'b1;
    pressed   = 16'h0011;
    scans(5);
    check("ghost_key_held", int'(key_held), 0);
    check("ghost_event_count", ev_q.size(), 0);
    check("ghost_key_valid", int'(key_valid), 0);

    // Overflow: five presses with consumer stalled
    do_reset();
    key_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      pressed = 16'(1) << k;
      scans(3);
      pressed = '0;
      scans(3);
    end
    check("ovf_fifo_count", int'(fifo_count), 4);
    check("ovf_overflow", int'(overflow), 1);
    check("ovf_key_valid", int'(key_valid), 1);
    check("ovf_head_code", int'(key_code), 1);
    for (int k = 0; k < 4; k++) pop_one();
    check("ovf_pop_count", ev_q.size(), 4);
    for (int k = 0; k < ev_q.size(); k++) check("ovf_pop_code", ev_q[k], k + 1);
    check("ovf_drained_count", int'(fifo_count), 0);
    check("ovf_drained_valid", int'(key_valid), 0);
    check("ovf_sticky", int'(overflow), 1);
    do_reset();
    check("ovf_cleared_by_rst", int'(overflow), 0);

    // Long hold of key 9: auto-repeat only when the macro is defined
    key_ready = 1'b1;
    pressed   = 16'(1) << 9;
    scans(15);
    repeat (3) @(posedge clk);
    #1;
    check("hold_key_held", int'(key_held), 1);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("hold_event_count", ev_q.size(), 5);
`else
    check("hold_event_count", ev_q.size(), 1);
`endif
    for (int k = 0; k < ev_q.size(); k++) check("hold_event_code", ev_q[k], 9);
    pressed = '0;
    scans(4);
    check("hold_released", int'(key_held), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
